// File: rtl/ai_player.sv
// ai_player: computer opponent for player 1 (left side) of the multi-ball paddle game.
// Every cycle it picks the most urgent left-moving ball and the nearer of player 1's two
// paddles, then registers a move command with the same encoding as the human play1_M input.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ballN_posx/posy, N=1..5    ball top-left position (signed pixels)
//   ballN_velx/vely, N=1..5    ball velocity; velx < 0 is toward player 1, vely unused
//   paddle1M_posx/posy, M=0,1  paddle top-left position; posx unused
//   action                     registered move command:
//                              0 hold, 1/2 paddle10 up/down, 3/4 paddle11 up/down
module ai_player #(
    parameter logic signed [10:0] PAD_HALF_H = 11'sd40,
    parameter logic signed [10:0] BALL_HALF  = 11'sd8,
    parameter logic signed [10:0] DEADBAND   = 11'sd6,
    parameter logic signed [10:0] HOME_Y     = 11'sd240
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [10:0] ball1_posx,
    input  logic signed [10:0] ball1_posy,
    input  logic signed [10:0] ball1_velx,
    input  logic signed [10:0] ball1_vely,
    input  logic signed [10:0] ball2_posx,
    input  logic signed [10:0] ball2_posy,
    input  logic signed [10:0] ball2_velx,
    input  logic signed [10:0] ball2_vely,
    input  logic signed [10:0] ball3_posx,
    input  logic signed [10:0] ball3_posy,
    input  logic signed [10:0] ball3_velx,
    input  logic signed [10:0] ball3_vely,
    input  logic signed [10:0] ball4_posx,
    input  logic signed [10:0] ball4_posy,
    input  logic signed [10:0] ball4_velx,
    input  logic signed [10:0] ball4_vely,
    input  logic signed [10:0] ball5_posx,
    input  logic signed [10:0] ball5_posy,
    input  logic signed [10:0] ball5_velx,
    input  logic signed [10:0] ball5_vely,
    input  logic signed [10:0] paddle10_posx,
    input  logic signed [10:0] paddle10_posy,
    input  logic signed [10:0] paddle11_posx,
    input  logic signed [10:0] paddle11_posy,
    output logic [2:0]         action
);

    // Differences of two 12-bit values are kept at 13 bits so they never wrap.
    localparam logic signed [12:0] DB = 13'(DEADBAND);

    logic signed [10:0] posx [5];
    logic signed [10:0] posy [5];
    logic signed [10:0] velx [5];

    assign posx = '{ball1_posx, ball2_posx, ball3_posx, ball4_posx, ball5_posx};
    assign posy = '{ball1_posy, ball2_posy, ball3_posy, ball4_posy, ball5_posy};
    assign velx = '{ball1_velx, ball2_velx, ball3_velx, ball4_velx, ball5_velx};

    // Vertical ball velocity and paddle x positions play no part in the policy.
    logic unused_inputs;
    assign unused_inputs = ^{ball1_vely, ball2_vely, ball3_vely, ball4_vely, ball5_vely,
                             paddle10_posx, paddle11_posx};

    function automatic logic signed [12:0] abs13(input logic signed [12:0] v);
        return (v < 0) ? -v : v;
    endfunction

    logic               found;
    logic [2:0]         best_idx;
    logic signed [10:0] best_x;
    logic signed [12:0] ty;
    logic signed [12:0] c0;
    logic signed [12:0] c1;
    logic signed [12:0] d0;
    logic signed [12:0] d1;
    logic signed [12:0] err;
    logic               sel1;
    logic [2:0]         action_d;
    logic [2:0]         action_q;

    always_comb begin
        found    = 1'b0;
        best_idx = 3'd0;
        best_x   = '0;
        // Strict less-than keeps the lowest index on equal posx.
        for (int i = 0; i < 5; i++) begin
            if (velx[i] < 0 && posx[i] >= 0 && (!found || posx[i] < best_x)) begin
                found    = 1'b1;
                best_idx = 3'(i);
                best_x   = posx[i];
            end
        end

        ty = found ? 13'(posy[best_idx]) + 13'(BALL_HALF) : 13'(HOME_Y);
        c0 = 13'(paddle10_posy) + 13'(PAD_HALF_H);
        c1 = 13'(paddle11_posy) + 13'(PAD_HALF_H);
        d0 = abs13(ty - c0);
        d1 = abs13(ty - c1);
        // With nothing to chase, paddle10 alone goes home.
        sel1 = found && (d1 < d0);
        err  = ty - (sel1 ? c1 : c0);

        action_d = 3'd0;
        if (err < -DB) begin
            action_d = sel1 ? 3'd3 : 3'd1;
        end else if (err > DB) begin
            action_d = sel1 ? 3'd4 : 3'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            action_q <= 3'd0;
        end else begin
            action_q <= action_d;
        end
    end

    assign action = action_q;

endmodule

// File: tb/tb_ai_player.sv
module tb_ai_player;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [10:0] bx  [5];
    logic signed [10:0] by  [5];
    logic signed [10:0] bvx [5];
    logic signed [10:0] bvy [5];
    logic signed [10:0] p10x, p10y, p11x, p11y;
    logic [2:0]         action;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    ai_player dut (
        .clk(clk), .rst_n(rst_n),
        .ball1_posx(bx[0]), .ball1_posy(by[0]), .ball1_velx(bvx[0]), .ball1_vely(bvy[0]),
        .ball2_posx(bx[1]), .ball2_posy(by[1]), .ball2_velx(bvx[1]), .ball2_vely(bvy[1]),
        .ball3_posx(bx[2]), .ball3_posy(by[2]), .ball3_velx(bvx[2]), .ball3_vely(bvy[2]),
        .ball4_posx(bx[3]), .ball4_posy(by[3]), .ball4_velx(bvx[3]), .ball4_vely(bvy[3]),
        .ball5_posx(bx[4]), .ball5_posy(by[4]), .ball5_velx(bvx[4]), .ball5_vely(bvy[4]),
        .paddle10_posx(p10x), .paddle10_posy(p10y),
        .paddle11_posx(p11x), .paddle11_posy(p11y),
        .action(action)
    );

    // Reference policy on plain integers.
    function automatic int model();
        int best = -1;
        int ty, c0, c1, d0, d1, e;
        bit use1;
        for (int i = 0; i < 5; i++) begin
            if (int'(bvx[i]) < 0 && int'(bx[i]) >= 0) begin
                if (best < 0 || int'(bx[i]) < int'(bx[best])) best = i;
            end
        end
        ty = (best < 0) ? 240 : int'(by[best]) + 8;
        c0 = int'(p10y) + 40;
        c1 = int'(p11y) + 40;
        d0 = (ty > c0) ? ty - c0 : c0 - ty;
        d1 = (ty > c1) ? ty - c1 : c1 - ty;
        use1 = (best >= 0) && (d1 < d0);
        e = ty - (use1 ? c1 : c0);
        if (e < -6) return use1 ? 3 : 1;
        if (e > 6) return use1 ? 4 : 2;
        return 0;
    endfunction

    task automatic idle_balls();
        for (int i = 0; i < 5; i++) begin
            bx[i] = 11'sd400; by[i] = 11'sd100; bvx[i] = 11'sd2; bvy[i] = -11'sd1;
        end
        p10x = 11'sd10; p11x = 11'sd60;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < 5; i++) begin
            bx[i]  = 11'($signed($urandom_range(0, 900)) - 100);
            by[i]  = 11'($urandom_range(0, 600));
            bvx[i] = 11'($signed($urandom_range(0, 6)) - 3);
            bvy[i] = 11'($signed($urandom_range(0, 6)) - 3);
        end
        if ($urandom_range(0, 3) == 0) bx[1] = bx[0];
        p10y = 11'($urandom_range(0, 600));
        p11y = 11'($urandom_range(0, 600));
        p10x = 11'($urandom_range(0, 100));
        p11x = 11'($urandom_range(0, 100));
    endtask

    task automatic test_reset();
        int exp;
        randomize_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if (action !== 3'd0) $display("FAIL reset_immediate: action=%0d want 0", action);
        else passes++;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (action !== 3'd0) $display("FAIL reset_held: action=%0d want 0", action);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (action !== 3'd0) $display("FAIL reset_release: action=%0d want 0", action);
        else passes++;
        exp = model();
        @(posedge clk);
        #1;
        checks++;
        if (int'(action) !== exp) $display("FAIL reset_first_edge: action=%0d want %0d", action, exp);
        else passes++;
    endtask

    task automatic test_no_eligible();
        idle_balls();
        p10y = 11'sd100; p11y = 11'sd200;
        @(posedge clk);
        #1;
        checks++;
        if (action !== 3'd2) $display("FAIL no_eligible: action=%0d want 2", action);
        else passes++;
    endtask

    task automatic test_selection();
        idle_balls();
        bx[1] = 11'sd50;  by[1] = 11'sd292; bvx[1] = -11'sd3;
        bx[3] = 11'sd300; by[3] = 11'sd0;   bvx[3] = -11'sd3;
        p10y = 11'sd0; p11y = 11'sd200;
        @(posedge clk);
        #1;
        checks++;
        if (action !== 3'd4) $display("FAIL selection: action=%0d want 4", action);
        else passes++;
    endtask

    task automatic test_up_move();
        idle_balls();
        bx[0] = 11'sd20; by[0] = 11'sd12; bvx[0] = -11'sd1;
        p10y = 11'sd200; p11y = 11'sd300;
        @(posedge clk);
        #1;
        checks++;
        if (action !== 3'd1) $display("FAIL up_move: action=%0d want 1", action);
        else passes++;
    endtask

    task automatic test_deadband();
        int posys [4] = '{138, 139, 126, 125};
        int wants [4] = '{0, 2, 0, 1};
        idle_balls();
        bx[0] = 11'sd10; bvx[0] = -11'sd1;
        p10y = 11'sd100; p11y = 11'sd900;
        for (int k = 0; k < 4; k++) begin
            by[0] = 11'(posys[k]);
            @(posedge clk);
            #1;
            checks++;
            if (int'(action) !== wants[k])
                $display("FAIL deadband_%0d: action=%0d want %0d", k, action, wants[k]);
            else passes++;
        end
    endtask

    task automatic test_ties();
        idle_balls();
        bx[1] = 11'sd100; by[1] = 11'sd92;  bvx[1] = -11'sd1;
        bx[2] = 11'sd100; by[2] = 11'sd500; bvx[2] = -11'sd1;
        p10y = 11'sd0; p11y = 11'sd120;
        @(posedge clk);
        #1;
        checks++;
        if (action !== 3'd2) $display("FAIL ties: action=%0d want 2", action);
        else passes++;
    endtask

    task automatic test_random();
        int exp;
        for (int n = 0; n < 300; n++) begin
            randomize_inputs();
            exp = model();
            @(posedge clk);
            #1;
            checks++;
            if (int'(action) !== exp) $display("FAIL random_%0d: action=%0d want %0d", n, action, exp);
            else passes++;
        end
    endtask

    task automatic test_mid_reset();
        idle_balls();
        bx[0] = 11'sd20; by[0] = 11'sd12; bvx[0] = -11'sd1;
        p10y = 11'sd200; p11y = 11'sd300;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (action !== 3'd0) $display("FAIL mid_reset: action=%0d want 0", action);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (action !== 3'd1) $display("FAIL after_mid_reset: action=%0d want 1", action);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_no_eligible();
        test_selection();
        test_up_move();
        test_deadband();
        test_ties();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
